mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 28 ++
 rtl/mem_word_array.sv | 27 ++
 rtl/mem_responder.sv | 119 +++++++++++
 tb/tb_mem_responder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the single-outstanding memory responder.
// Holds the FSM encoding, datapath widths and the address error check.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int OFF_W  = 2;
    localparam int WIDX_W = ADDR_W - OFF_W;
    localparam int CNT_W  = 4;

    // Misaligned byte address or word index beyond the array.
    function automatic logic addr_err(
        input logic [ADDR_W-1:0] a,
        input logic [31:0]       depth
    );
        logic [31:0] widx;
        widx = {{OFF_W{1'b0}}, a[ADDR_W-1:OFF_W]};
        return (a[OFF_W-1:0] != '0) || (widx >= depth);
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word-wide storage with per-byte write enables and combinational read.
// Contents are deliberately not reset.
module mem_word_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    // Byte-lane writes; lanes with we_i low keep their old contents.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_responder.sv
// Load/store responder: accepts one request, waits LATENCY cycles,
// then holds the response until the initiator takes it.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               write_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [BE_W-1:0]    be_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               err_q;

    logic               accept;
    logic               access;
    logic               acc_write;
    logic               acc_err;
    logic [ADDR_W-1:0]  acc_addr;
    logic [DATA_W-1:0]  acc_wdata;
    logic [BE_W-1:0]    acc_be;
    logic [BE_W-1:0]    mem_we;
    logic [DATA_W-1:0]  mem_rdata;

    // Gated by rst_n so ready is low while reset is held.
    assign req_ready  = rst_n && (state_q == ST_IDLE);
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // With zero latency the access uses the live request, else the capture.
    assign access = (accept && (LATENCY == 0)) ||
                    ((state_q == ST_WAIT) && (cnt_q == CNT_W'(1)));

    assign acc_write = (state_q == ST_IDLE) ? req_write : write_q;
    assign acc_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
    assign acc_be    = (state_q == ST_IDLE) ? req_be    : be_q;
    assign acc_err   = addr_err(acc_addr, 32'(DEPTH));

    assign mem_we = (access && acc_write && !acc_err) ? acc_be : '0;

    mem_word_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk_i   (clk),
        .we_i    (mem_we),
        .addr_i  (acc_addr[AW+1:2]),
        .wdata_i (acc_wdata),
        .rdata_o (mem_rdata)
    );

    // Request FSM with captured request fields and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (access) begin
                rdata_q <= (acc_write || acc_err) ? '0 : mem_rdata;
                err_q   <= acc_err;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        write_q <= req_write;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        cnt_q   <= CNT_W'(LATENCY);
                        state_q <= (LATENCY == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_q <= ST_IDLE;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomised bench for mem_responder against a word/byte-lane model.
// Covers the default build and a zero-latency build.
module tb_mem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk;
    logic        rst_n;

    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;

    logic        req_valid_b, req_ready_b, req_write_b;
    logic [31:0] req_addr_b, req_wdata_b;
    logic [3:0]  req_be_b;
    logic        resp_valid_b, resp_ready_b, resp_err_b;
    logic [31:0] resp_rdata_b;

    int checks;
    int errors;

    logic [31:0] mref [DEPTH];
    logic [3:0]  kref [DEPTH];
    logic [31:0] bref [8];

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid_b),
        .req_ready  (req_ready_b),
        .req_write  (req_write_b),
        .req_addr   (req_addr_b),
        .req_wdata  (req_wdata_b),
        .req_be     (req_be_b),
        .resp_valid (resp_valid_b),
        .resp_ready (resp_ready_b),
        .resp_rdata (resp_rdata_b),
        .resp_err   (resp_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: error rule, byte-lane merge, known-byte mask for loads.
    task automatic model(input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be,
                         output logic [31:0] exp_rd, output logic exp_err,
                         output logic [31:0] m32);
        int unsigned idx;
        idx = a / 4;
        exp_err = (a % 4 != 0) || (idx >= DEPTH);
        exp_rd  = '0;
        m32     = '1;
        if (!exp_err) begin
            if (w) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mref[idx][8*i +: 8] = wd[8*i +: 8];
                        kref[idx][i] = 1'b1;
                    end
                end
            end else begin
                exp_rd = mref[idx];
                for (int i = 0; i < 4; i++) begin
                    m32[8*i +: 8] = {8{kref[idx][i]}};
                end
            end
        end
    endtask

    // One transaction on the LATENCY=2 instance; starts 1 unit after posedge.
    task automatic xact(input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        input int hold, input logic noise,
                        output logic [31:0] got);
        logic [31:0] exp_rd, m32, snap_rd;
        logic        exp_err, snap_err;
        int          n;
        model(w, a, wd, be, exp_rd, exp_err, m32);
        chk("rdy_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = wd;
        req_be    = be;
        @(posedge clk); #1;
        n = 1;
        while (!resp_valid && n < 20) begin
            chk("rdy_busy", {31'd0, req_ready}, 32'd0);
            req_valid  = noise ? 1'($urandom % 2) : 1'b0;
            req_write  = 1'($urandom % 2);
            req_addr   = $urandom;
            req_wdata  = $urandom;
            req_be     = 4'($urandom);
            resp_ready = noise ? 1'($urandom % 2) : 1'b0;
            @(posedge clk); #1;
            n++;
        end
        got = resp_rdata;
        chk("latency", n, LAT + 1);
        if (!resp_valid) begin
            req_valid  = 1'b0;
            resp_ready = 1'b0;
            return;
        end
        chk("err", {31'd0, resp_err}, {31'd0, exp_err});
        chk("rdata", resp_rdata & m32, exp_rd & m32);
        snap_rd    = resp_rdata;
        snap_err   = resp_err;
        resp_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_vld", {31'd0, resp_valid}, 32'd1);
            chk("hold_rd", resp_rdata, snap_rd);
            chk("hold_err", {31'd0, resp_err}, {31'd0, snap_err});
            chk("hold_rdy", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        chk("vld_clr", {31'd0, resp_valid}, 32'd0);
        chk("rdy_back", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] got, a, wd;
        logic        w;
        int          r;
        checks = 0;
        errors = 0;
        for (int i = 0; i < DEPTH; i++) kref[i] = 4'h0;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
        req_be = 0; resp_ready = 0;
        req_valid_b = 0; req_write_b = 0; req_addr_b = 0;
        req_wdata_b = 0; req_be_b = 0; resp_ready_b = 0;

        rst_n = 1'b0;
        #3;
        chk("rst_rdy", {31'd0, req_ready}, 32'd0);
        chk("rst_vld", {31'd0, resp_valid}, 32'd0);
        chk("rst_rd", resp_rdata, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_rdy", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;

        xact(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, got);
        xact(0, 32'h10, 32'h0, 4'h0, 0, 0, got);
        chk("basic_ld", got, 32'hDEADBEEF);

        xact(1, 32'h20, 32'h11223344, 4'hF, 0, 0, got);
        xact(1, 32'h20, 32'hAABBCCDD, 4'b0101, 1, 0, got);
        xact(0, 32'h20, 32'h0, 4'h0, 0, 0, got);
        chk("be_merge", got, 32'h11BB33DD);
        xact(1, 32'h20, 32'h55667788, 4'h0, 0, 0, got);
        xact(0, 32'h20, 32'h0, 4'hF, 0, 0, got);
        chk("be_zero", got, 32'h11BB33DD);

        xact(1, 32'h0, 32'h01020304, 4'hF, 0, 0, got);
        xact(0, 32'h12, 32'h0, 4'h0, 0, 0, got);
        xact(0, DEPTH * 4, 32'h0, 4'h0, 0, 0, got);
        xact(1, 32'h12, 32'hFFFFFFFF, 4'hF, 0, 0, got);
        xact(1, DEPTH * 4, 32'hFFFFFFFF, 4'hF, 0, 0, got);
        xact(0, 32'h10, 32'h0, 4'h0, 0, 0, got);
        chk("err_keep10", got, 32'hDEADBEEF);
        xact(0, 32'h0, 32'h0, 4'h0, 0, 0, got);
        chk("err_keep0", got, 32'h01020304);

        xact(0, 32'h10, 32'h0, 4'h0, 5, 0, got);

        xact(1, 32'h30, 32'hCAFEF00D, 4'hF, 0, 0, got);
        req_valid = 1; req_write = 1; req_addr = 32'h30;
        req_wdata = 32'h0BADF00D; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_rdy", {31'd0, req_ready}, 32'd0);
        chk("abort_vld", {31'd0, resp_valid}, 32'd0);
        chk("abort_rd", resp_rdata, 32'd0);
        chk("abort_err", {31'd0, resp_err}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_rel", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        xact(0, 32'h30, 32'h0, 4'h0, 0, 0, got);
        chk("abort_keep", got, 32'hCAFEF00D);

        for (int t = 0; t < 150; t++) begin
            r = $urandom % 10;
            if (r < 8)       a = 32'($urandom_range(0, 31)) * 4;
            else if (r == 8) a = 32'($urandom_range(0, 127)) * 4 + 32'($urandom_range(1, 3));
            else             a = DEPTH * 4 + 32'($urandom_range(0, 63)) * 4;
            w  = 1'($urandom % 2);
            wd = $urandom;
            xact(w, a, wd, 4'($urandom), $urandom % 4, 1, got);
        end

        req_valid_b  = 1'b1;
        resp_ready_b = 1'b1;
        for (int i = 0; i < 16; i++) begin
            w  = (i < 8);
            wd = $urandom;
            req_write_b = w;
            req_addr_b  = 32'(i % 8) * 4;
            req_wdata_b = wd;
            req_be_b    = 4'hF;
            chk("b_rdy", {31'd0, req_ready_b}, 32'd1);
            @(posedge clk); #1;
            chk("b_vld", {31'd0, resp_valid_b}, 32'd1);
            chk("b_busy", {31'd0, req_ready_b}, 32'd0);
            chk("b_err", {31'd0, resp_err_b}, 32'd0);
            chk("b_rdata", resp_rdata_b, w ? 32'd0 : bref[i % 8]);
            if (w) bref[i % 8] = wd;
            @(posedge clk); #1;
        end
        req_valid_b = 1'b0;
        @(posedge clk); #1;
        chk("b_idle", {31'd0, resp_valid_b}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
